dmc_wb_cache: RTL
=================

DMC_WB_CACHE -- requirements
Module: dmc_wb_cache

Interface
REQ-001 SHALL: parameter ADDR_W, default 12, CPU/memory word-address width.
REQ-002 SHALL: parameter DATA_W, default 16, data word width.
REQ-003 SHALL: parameter INDEX_W, default 8, line-index width; 1 <= INDEX_W < ADDR_W; TAG_W = ADDR_W-INDEX_W; one word per line; 2^INDEX_W lines.
REQ-004 SHALL: clk  input  1  single clock, all state changes on rising edge.
REQ-005 SHALL: clr  input  1  reset, asynchronous, active-high.
REQ-006 SHALL: cpu_rd  input  1  read request; cpu_wr  input  1  write request.
REQ-007 SHALL: cpu_addr  input  ADDR_W  request address; cpu_din  input  DATA_W  write data.
REQ-008 SHALL: cpu_dout  output  DATA_W  read data, valid while cpu_ack=1; cpu_ack  output  1  one-cycle completion pulse.
REQ-009 SHALL: cpu_busy  output  1  high from accept edge until the cycle cpu_ack is high.
REQ-010 SHALL: mem_rd  output  1, mem_wr  output  1, mem_addr  output  ADDR_W, mem_dout  output  DATA_W (write-back data).
REQ-011 SHALL: mem_din  input  DATA_W  fill data; mem_ack  input  1  memory completion, sampled on clk.

Function
REQ-012 SHALL: each line hold valid, dirty, tag[TAG_W-1:0], data[DATA_W-1:0]; index = cpu_addr[INDEX_W-1:0], tag = upper TAG_W bits.
REQ-013 SHALL: FSM states IDLE, WBACK, FILL, DONE.
REQ-014 SHALL: in IDLE with cpu_rd|cpu_wr, latch addr/din/op at the edge; cpu_wr takes priority when both asserted (operation is a write); requests in other states ignored.
REQ-015 SHALL: hit (valid & tag match) in IDLE: read loads cpu_dout with line data, write stores cpu_din and sets dirty; next state DONE; hit latency = cpu_ack high 1 cycle after accept edge.
REQ-016 SHALL: miss with victim valid&dirty -> WBACK: mem_wr=1, mem_addr={victim tag,index}, mem_dout=victim data, held stable until mem_ack sampled high, then FILL.
REQ-017 SHALL: miss with victim invalid or clean -> FILL directly (no write-back).
REQ-018 SHALL: FILL: mem_rd=1, mem_addr=latched address, held until mem_ack; on mem_ack line <= {valid=1, tag, mem_din, dirty=0}, read loads cpu_dout=mem_din; write-allocate: write stores latched cpu_din and sets dirty; then DONE.
REQ-019 SHALL: DONE: cpu_ack=1 for exactly one cycle, cpu_busy=1, mem_rd=mem_wr=0, return to IDLE; new request accepted at the following edge.
REQ-020 SHALL: mem_rd and mem_wr never both high; both low in IDLE and DONE; mem_ack ignored outside WBACK/FILL.
REQ-021 SHALL: cpu_dout hold its last value until the next read completion.

Reset
REQ-022 SHALL: clr=1 asynchronously clears all valid and dirty bits, state=IDLE, cpu_ack=cpu_busy=mem_rd=mem_wr=0, cpu_dout=mem_addr=mem_dout=0; tag/data arrays not reset.
REQ-023 SHALL: clr mid-WBACK/FILL abandons the transaction; no cpu_ack issued; dirty data discarded.

Configuration
REQ-024 SHALL: with DMC_STATS_EN defined, add outputs hit_cnt, miss_cnt (16 bits each, reset 0), incremented once per completed request classified at accept, saturating at 0xFFFF; without it, these ports and counters do not exist and behaviour is otherwise identical.

Verification
REQ-025 SHALL: after reset, read 0x123, mem returns 0xBEEF with mem_ack 2 cycles later -> mem_rd high, mem_addr=0x123, cpu_ack with cpu_dout=0xBEEF; re-read 0x123 -> no mem_rd, cpu_ack 1 cycle after accept, 0xBEEF.
REQ-026 SHALL: write 0x123=0x1111 (hit), then read 0x523 -> mem_wr with mem_addr=0x123, mem_dout=0x1111 first, then mem_rd 0x523, then cpu_ack.
REQ-027 SHALL: after reset write 0x044=0xA5A5 -> mem_rd 0x044 fill, no mem_wr, cpu_ack; read 0x044 -> hit returning 0xA5A5; read 0x144 -> write-back of 0xA5A5 to 0x044.
REQ-028 SHALL: clr pulsed while in FILL -> mem_rd low immediately, no cpu_ack; subsequent read same address misses.
REQ-029 SHALL: cpu_rd=cpu_wr=1 to 0x010 with din 0x0F0F -> treated as write; later read 0x010 returns 0x0F0F.
REQ-030 SHALL: DMC_STATS_EN: one miss then two hits -> miss_cnt=1, hit_cnt=2.

Source files
------------

// File: rtl/dmc_wb_cache.sv
// dmc_wb_cache: direct-mapped, write-back, write-allocate cache with one word per line.
// The CPU side uses a request/ack handshake. The memory side uses a held-request/ack handshake.
// Optional macro DMC_STATS_EN adds the saturating hit_cnt and miss_cnt outputs.
module dmc_wb_cache #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ack,
    output logic              cpu_busy,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din,
    input  logic              mem_ack
`ifdef DMC_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, WBACK, FILL, DONE} state_t;
    state_t state;

    // Only valid and dirty are reset. A cleared valid bit makes stale tag and data harmless.
    logic [LINES-1:0]  valid, dirty;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_din;
    logic               lat_wr;
    logic               req, hit, victim_dirty;
    logic [INDEX_W-1:0] req_idx, lat_idx, line_idx;
    logic [TAG_W-1:0]   req_tag, lat_tag, line_tag;
    logic [DATA_W-1:0]  line_data;
    logic               line_we;

    assign req          = cpu_rd | cpu_wr;
    assign req_idx      = cpu_addr[INDEX_W-1:0];
    assign req_tag      = cpu_addr[ADDR_W-1:INDEX_W];
    assign lat_idx      = lat_addr[INDEX_W-1:0];
    assign lat_tag      = lat_addr[ADDR_W-1:INDEX_W];
    assign hit          = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign victim_dirty = valid[req_idx] & dirty[req_idx];

    // Single write port into the tag/data arrays: write hits in IDLE, line refill at the end of FILL
    always_comb begin
        line_we   = 1'b0;
        line_idx  = req_idx;
        line_tag  = req_tag;
        line_data = cpu_din;
        if (state == IDLE && cpu_wr && hit) begin
            line_we = 1'b1;
        end else if (state == FILL && mem_ack) begin
            line_we   = 1'b1;
            line_idx  = lat_idx;
            line_tag  = lat_tag;
            line_data = lat_wr ? lat_din : mem_din;
        end
    end

    // Tag/data storage, no reset
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[line_idx]  <= line_tag;
            data_mem[line_idx] <= line_data;
        end
    end

    // Control FSM with registered CPU and memory outputs; a write wins when rd and wr are both set
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            valid    <= '0;
            dirty    <= '0;
            cpu_ack  <= 1'b0;
            cpu_busy <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            cpu_dout <= '0;
            mem_addr <= '0;
            mem_dout <= '0;
            lat_addr <= '0;
            lat_din  <= '0;
            lat_wr   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    lat_addr <= cpu_addr;
                    lat_din  <= cpu_din;
                    lat_wr   <= cpu_wr;
                    cpu_busy <= 1'b1;
                    if (hit) begin
                        if (cpu_wr) dirty[req_idx] <= 1'b1;
                        else        cpu_dout       <= data_mem[req_idx];
                        cpu_ack <= 1'b1;
                        state   <= DONE;
                    end else if (victim_dirty) begin
                        mem_wr   <= 1'b1;
                        mem_addr <= {tag_mem[req_idx], req_idx};
                        mem_dout <= data_mem[req_idx];
                        state    <= WBACK;
                    end else begin
                        mem_rd   <= 1'b1;
                        mem_addr <= cpu_addr;
                        state    <= FILL;
                    end
                end
                WBACK: if (mem_ack) begin
                    mem_wr   <= 1'b0;
                    mem_rd   <= 1'b1;
                    mem_addr <= lat_addr;
                    state    <= FILL;
                end
                FILL: if (mem_ack) begin
                    mem_rd         <= 1'b0;
                    valid[lat_idx] <= 1'b1;
                    dirty[lat_idx] <= lat_wr;
                    if (!lat_wr) cpu_dout <= mem_din;
                    cpu_ack <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    cpu_ack  <= 1'b0;
                    cpu_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMC_STATS_EN
    logic lat_hit;

    // Hit/miss is classified at accept and counted only when the request completes
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            lat_hit  <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == IDLE && req) lat_hit <= hit;
            if (state == DONE) begin
                if (lat_hit && hit_cnt != 16'hFFFF)    hit_cnt  <= hit_cnt + 16'd1;
                if (!lat_hit && miss_cnt != 16'hFFFF)  miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
